// File: rtl/imem_loader_pkg.sv
// Shared CPU loader definitions: FSM state encodings, frame marker and IMEM geometry.
// fetch_module indexes instruction memory with pc[12:1], so it uses IMEM_ADDR_W as well.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W   = 12;
  localparam int unsigned INSTR_W       = 16;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LEN_HI  = 3'd1;
  localparam state_t S_LEN_LO  = 3'd2;
  localparam state_t S_DATA_HI = 3'd3;
  localparam state_t S_DATA_LO = 3'd4;
  localparam state_t S_CHECK   = 3'd5;
  localparam state_t S_RUN     = 3'd6;
  localparam state_t S_ERR     = 3'd7;

  // True from the length field through the checksum byte.
  function automatic logic in_frame(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte link from the host plus the instruction-memory write port.
// master = host/memory side, slave = imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_wen, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_wen, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC/LEN/DATA/CSUM frames from a byte stream,
// writes 16-bit words sequentially and holds the CPU in reset until an image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned DATA_W    = INSTR_W,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned MAX_WORDS = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_err
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_reset;
  logic              r_load_err;
  logic [7:0]        r_len_hi;
  logic [7:0]        r_hi;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_left;

  logic              w_acc;
  logic [15:0]       w_len;

  assign w_acc = bus.rx_valid & r_rx_ready;
  assign w_len = {r_len_hi, bus.rx_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_load_err  <= 1'b0;
      r_len_hi    <= '0;
      r_hi        <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_left      <= '0;
    end else begin
      r_rx_ready <= 1'b1;
      r_wen      <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_IDLE, S_RUN, S_ERR: begin
            // Only the marker starts a frame; anything else between frames is dropped.
            if (bus.rx_data == SYNC_BYTE) begin
              r_state     <= S_LEN_HI;
              r_load_err  <= 1'b0;
              r_cpu_reset <= 1'b1;
              r_sum       <= '0;
            end
          end
          S_LEN_HI: begin
            r_len_hi <= bus.rx_data;
            r_state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            if (w_len > MAX_N) begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA_HI;
              r_left  <= w_len;
              r_idx   <= '0;
            end
          end
          S_DATA_HI: begin
            r_hi    <= bus.rx_data;
            r_sum   <= r_sum + bus.rx_data;
            r_state <= S_DATA_LO;
          end
          S_DATA_LO: begin
            r_wen   <= 1'b1;
            r_wdata <= DATA_W'({r_hi, bus.rx_data});
            r_waddr <= r_idx;
            r_idx   <= r_idx + ADDR_W'(1);
            r_left  <= r_left - 16'd1;
            r_sum   <= r_sum + bus.rx_data;
            r_state <= (r_left == 16'd1) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            if (bus.rx_data == r_sum) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.imem_wen   = r_wen;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_reset      = r_cpu_reset;
  assign load_err       = r_load_err;
  assign busy           = in_frame(r_state);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand sequences and random frames
// checked against a frame-level reference model.
module tb_imem_loader;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_reset, busy, load_err;

  imem_loader_if #(.ADDR_W(12), .DATA_W(16)) bus();

  imem_loader #(
    .ADDR_W(12), .DATA_W(16), .SYNC_BYTE(8'hA5), .MAX_WORDS(4096)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .load_err(load_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [27:0] obs[$];
  logic [27:0] exp_w[$];
  logic [7:0]  stim[$];
  logic        m_cr, m_le;

  typedef struct {
    string       name;
    int          n;
    logic [63:0] b;
    logic        cr;
    logic        le;
    int          nw;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clock) begin
    #1;
    if (bus.imem_wen === 1'b1) obs.push_back({bus.imem_waddr, bus.imem_wdata});
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Frame-level model: scan for the marker, read the length, take 2N bytes, compare sum.
  task automatic model_stream();
    int i = 0;
    int n;
    logic [7:0] sum, hi, lo;
    exp_w.delete();
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      m_cr = 1'b1;
      m_le = 1'b0;
      n = int'({stim[i+1], stim[i+2]});
      i += 3;
      if (n > 4096) begin
        m_le = 1'b1;
        continue;
      end
      sum = 8'd0;
      for (int k = 0; k < n; k++) begin
        hi = stim[i + 2*k];
        lo = stim[i + 2*k + 1];
        exp_w.push_back({12'(k), hi, lo});
        sum = sum + hi + lo;
      end
      i += 2 * n;
      if (stim[i] == sum) m_cr = 1'b0;
      else                m_le = 1'b1;
      i++;
    end
  endtask

  task automatic run_stream(input string name);
    int bad = -1;
    int nmin;
    model_stream();
    obs.delete();
    foreach (stim[j]) send_byte(stim[j]);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk({name, ".nwrites"}, obs.size(), exp_w.size());
    nmin = (obs.size() < exp_w.size()) ? obs.size() : exp_w.size();
    for (int k = 0; k < nmin; k++)
      if (bad < 0 && obs[k] !== exp_w[k]) bad = k;
    if (bad >= 0)
      chk({name, ".write"}, obs[bad], exp_w[bad]);
    else if (nmin > 0)
      chk({name, ".write"}, obs[nmin-1], exp_w[nmin-1]);
    chk({name, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [63:0] vb;
    logic [7:0]  sum, d;
    int n, mode;

    vecs[0] = '{"good2",   8, 64'hA500021234ABCDBE, 1'b0, 1'b0, 2};
    vecs[1] = '{"badsum",  8, 64'hA500021234ABCDBF, 1'b1, 1'b1, 2};
    vecs[2] = '{"oversz",  3, 64'hA510010000000000, 1'b1, 1'b1, 0};
    vecs[3] = '{"good1",   6, 64'hA50001FFA5A40000, 1'b0, 1'b0, 1};
    vecs[4] = '{"runjunk", 3, 64'h0011220000000000, 1'b0, 1'b0, 0};
    vecs[5] = '{"n0bad",   4, 64'hA500000100000000, 1'b1, 1'b1, 0};
    vecs[6] = '{"junkn0",  6, 64'h00FFA50000000000, 1'b0, 1'b0, 0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    m_cr = 1'b1;
    m_le = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst.rx_ready", bus.rx_ready, 1'b0);
    chk("rst.cpu_reset", cpu_reset, 1'b1);
    chk("rst.wen", bus.imem_wen, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.load_err", load_err, 1'b0);
    chk("rst.waddr", bus.imem_waddr, 12'h000);
    chk("rst.wdata", bus.imem_wdata, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rel.rx_ready", bus.rx_ready, 1'b1);

    // Write latency, CSUM release and reload from RUN
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    send_byte(8'h34);
    chk("lat.wen", bus.imem_wen, 1'b1);
    chk("lat.waddr", bus.imem_waddr, 12'h000);
    chk("lat.wdata", bus.imem_wdata, 16'h1234);
    chk("lat.busy", busy, 1'b1);
    send_byte(8'h46);
    chk("lat.wen_drop", bus.imem_wen, 1'b0);
    chk("lat.cpu_run", cpu_reset, 1'b0);
    chk("lat.busy_done", busy, 1'b0);
    send_byte(8'hA5);
    chk("reload.cpu_reset", cpu_reset, 1'b1);
    chk("reload.busy", busy, 1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("reload.cpu_run", cpu_reset, 1'b0);
    m_cr = 1'b0;
    m_le = 1'b0;

    // Vector table
    for (int v = 0; v < 7; v++) begin
      stim.delete();
      vb = vecs[v].b;
      for (int k = 0; k < vecs[v].n; k++) stim.push_back(vb[63 - 8*k -: 8]);
      run_stream(vecs[v].name);
      chk({vecs[v].name, ".cpu_reset"}, cpu_reset, vecs[v].cr);
      chk({vecs[v].name, ".load_err"}, load_err, vecs[v].le);
      chk({vecs[v].name, ".nw_table"}, obs.size(), vecs[v].nw);
    end

    // Largest image: N = 4096 fills every address exactly once
    stim.delete();
    stim.push_back(8'hA5); stim.push_back(8'h10); stim.push_back(8'h00);
    sum = 8'd0;
    for (int k = 0; k < 8192; k++) begin
      d = 8'($urandom);
      stim.push_back(d);
      sum = sum + d;
    end
    stim.push_back(sum);
    run_stream("max4096");
    chk("max4096.cpu_reset", cpu_reset, 1'b0);
    chk("max4096.lastaddr", (obs.size() > 0) ? 32'(obs[obs.size()-1][27:16]) : 32'hFFFF_FFFF, 32'h0000_0FFF);

    // Random frames against the model
    for (int r = 0; r < 12; r++) begin
      stim.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        d = 8'($urandom);
        stim.push_back((d == 8'hA5) ? 8'h5A : d);
      end
      mode = int'($urandom_range(0, 4));
      if (mode == 0) begin
        n = int'($urandom_range(4097, 65535));
        stim.push_back(8'hA5); stim.push_back(8'(n >> 8)); stim.push_back(8'(n));
      end else begin
        n = int'($urandom_range(0, 6));
        stim.push_back(8'hA5); stim.push_back(8'(n >> 8)); stim.push_back(8'(n));
        sum = 8'd0;
        for (int k = 0; k < 2*n; k++) begin
          d = 8'($urandom);
          stim.push_back(d);
          sum = sum + d;
        end
        stim.push_back((mode == 1) ? (sum ^ 8'h01) : sum);
      end
      run_stream($sformatf("rand%0d", r));
      chk($sformatf("rand%0d.cpu_reset", r), cpu_reset, m_cr);
      chk($sformatf("rand%0d.load_err", r), load_err, m_le);
    end

    // Reset pulsed mid-frame after two of three words
    obs.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst.cpu_reset", cpu_reset, 1'b1);
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.rx_ready", bus.rx_ready, 1'b0);
    chk("midrst.waddr", bus.imem_waddr, 12'h000);
    chk("midrst.nwrites", obs.size(), 2);
    chk("midrst.word1", (obs.size() > 1) ? 32'(obs[1]) : 32'hFFFF_FFFF, 32'h001_3344);
    @(negedge clock);
    reset_n = 1'b1;
    m_cr = 1'b1;
    m_le = 1'b0;
    stim.delete();
    stim.push_back(8'h55); stim.push_back(8'h66);
    run_stream("postrst");
    chk("postrst.cpu_reset", cpu_reset, 1'b1);
    chk("postrst.load_err", load_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
